sram_axi_master: RTL and testbench
==================================

# sram_axi_master

Upstream master adapter for the AXI-to-SRAM bridge. Converts a simple CPU-side SRAM-like request port (req/addr_ok/data_ok) into single-beat AXI read and write transactions that drive the bridge's AXI slave port. Only one transaction is outstanding at a time, which keeps the handshake ordering identical to what the bridge benches drive by hand. Together with the bridge, it forms the CPU-to-SRAM path in `top`.

## Interface
Parameters:
- ADDR_W, 32, address width (CPU side and AXI AxADDR)
- DATA_W, 32, data width. Fixed at 32 for this revision; wstrb is DATA_W/8.

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  CPU request valid
- wr  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  request address
- wdata  in  DATA_W  write data
- wstrb  in  4  write byte strobes
- addr_ok  out  1  request accepted this cycle (req & addr_ok)
- data_ok  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data; valid while data_ok=1, held afterwards
- err  out  1  with data_ok: response was not OKAY
- araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AXI read address
- arlen, arsize, arburst  out  8,3,2  constants 0, 3'b010, 2'b01
- rdata_i/rresp/rlast/rvalid/rready  in/in/in/in/out  DATA_W/2/1/1/1  AXI read data
- awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  AXI write address
- awlen, awsize, awburst  out  8,3,2  constants 0, 3'b010, 2'b01
- wdata_o/wstrb_o/wlast/wvalid/wready  out/out/out/out/in  DATA_W/4/1/1/1  AXI write data; wlast = wvalid
- bresp/bvalid/bready  in/in/out  2/1/1  AXI write response

## Operation
- FSM states: IDLE, RD_AR, RD_R, WR_REQ, WR_B.
- IDLE: addr_ok = 1 (combinational from state; does not depend on req). On req=1: latch addr, wdata, and wstrb; go to RD_AR if wr=0, else WR_REQ.
- RD_AR: arvalid=1 with the latched address. On arready, go to RD_R.
- RD_R: rready=1. On rvalid, capture rdata_i into rdata and set err = (rresp != 0), then go to IDLE. Assert data_ok as a registered pulse in the next cycle. rlast is ignored because every transfer is a single beat.
- WR_REQ: awvalid and wvalid are both raised on entry. Each one drops independently on the cycle after its own handshake. Go to WR_B once both handshakes are done, whether they occur in the same cycle or different cycles.
- WR_B: bready=1. On bvalid, set err = (bresp != 0) and go to IDLE. data_ok is a registered pulse in the next cycle.
- rready is 0 outside RD_R and bready is 0 outside WR_B. A stray rvalid or bvalid in other states is ignored, and no data_ok is produced.
- AXI outputs remain stable while valid=1 and ready=0.

## Timing
- Reset values: all valids/readies 0, addr_ok 0, data_ok 0, err 0, rdata 0, address and data outputs 0, state IDLE.
- Reset asserted mid-transaction: on the next edge every valid and ready drops to 0 and the state goes to IDLE. The transaction is abandoned with no data_ok.
- Read with zero-wait slave: req accepted at cycle N, arvalid=1 at N+1 (arready handshake), rready=1 at N+2 (rvalid handshake), data_ok=1 with rdata at N+3. The cycle N+3 is IDLE again, so addr_ok=1 and a back-to-back request is accepted in the same cycle as data_ok.
- Write with zero-wait slave: accepted at N, awvalid=wvalid=1 at N+1 (both handshakes), bready=1 at N+2 (bvalid), data_ok at N+3.
- Each wait cycle on arready, rvalid, awready, wready, or bvalid adds exactly one cycle. For writes, the latency is set by the later of the AW and W handshakes.
- addr_ok=0 in every non-IDLE state. At most one transaction is outstanding.

## Test plan
- Write then read: write addr 0x4, data 0xabcdaaaa, wstrb 0xF with a zero-wait bridge; then read 0x4. Required: data_ok at N+3 for each transaction, rdata = 0xabcdaaaa, err=0.
- Skewed write: awready delayed 3 cycles and wready immediate. Required: wvalid drops after 1 cycle, awvalid stays high until its handshake, and bready rises only after both handshakes complete.
- Back-to-back: req held high for reads of 0x0, 0x4, and 0x8. Required: each new request is accepted in the cycle data_ok is pulsed for the previous one, and exactly 3 data_ok pulses occur with no lost or duplicated requests.
- Backpressure: arready low for 5 cycles. Required: arvalid and araddr stay stable, addr_ok=0 throughout, and data_ok appears 5 cycles later than the zero-wait case.
- Error response: rresp=2'b10 on a read of 0x10. Required: data_ok=1 and err=1 in the same cycle, and err=0 on the next OKAY transaction.
- Reset mid-write: assert reset while in WR_B. Required: bready=0 and state IDLE on the next edge, no data_ok, and a following read of 0x4 completes normally.

Source files
------------

// File: rtl/sram_axi_master.sv
// sram_axi_master: SRAM-like CPU port (req/addr_ok/data_ok) to single-beat AXI4 read/write master.
// Latency: with a zero-wait slave, data_ok arrives 3 cycles after the accepting cycle; each slave wait cycle adds one.
// Backpressure: addr_ok only in IDLE (one transaction outstanding); AXI address/data hold stable while valid && !ready.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req/wr/addr/wdata/wstrb -> addr_ok, data_ok, rdata, err   CPU request/response side
//   ar*/r*                AXI read address and read data channels
//   aw*/w*/b*             AXI write address, write data and write response channels
module sram_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    // CPU side
    input  logic                req,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                addr_ok,
    output logic                data_ok,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    // AXI read address
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    // AXI read data
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    // AXI write address
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    // AXI write data
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    // AXI write response
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_REQ, WR_B} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic                  aw_done;   // AW handshake already taken in this write
    logic                  w_done;    // W handshake already taken in this write
    logic                  aw_hs;
    logic                  w_hs;

    // Every transfer is a single beat, so rlast carries no information.
    logic unused_rlast;
    assign unused_rlast = rlast;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; the write leaves WR_REQ once both AW and W have
    // handshaken, counting a handshake happening in the current cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req)     state_nxt = wr ? WR_REQ : RD_AR;
            RD_AR:   if (arready) state_nxt = RD_R;
            RD_R:    if (rvalid)  state_nxt = IDLE;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_B;
            WR_B:    if (bvalid)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Output logic (Moore, from state plus per-channel done flags)
    always_comb begin
        addr_ok = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state)
            IDLE:    addr_ok = ~reset;   // nothing is accepted while reset is held
            RD_AR:   arvalid = 1'b1;
            RD_R:    rready  = 1'b1;
            WR_REQ: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
            end
            WR_B:    bready  = 1'b1;
            default: ;
        endcase
    end

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    // Request latch, handshake tracking and the registered completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            data_ok <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            data_ok <= 1'b0;
            if (state == IDLE && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (state == RD_R && rvalid) begin
                rdata   <= rdata_i;
                err     <= (rresp != 2'b00);
                data_ok <= 1'b1;
            end
            if (state == WR_B && bvalid) begin
                err     <= (bresp != 2'b00);
                data_ok <= 1'b1;
            end
        end
    end

    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign wdata_o = wdata_q;
    assign wstrb_o = wstrb_q;
    assign wlast   = wvalid;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign awlen   = 8'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;

endmodule

// File: tb/tb_sram_axi_master.sv
// tb_sram_axi_master: directed bench for sram_axi_master with a small AXI slave model and a response scoreboard.
// Stimulus issues CPU requests and pushes the expected rdata/err/completion cycle; a monitor pops on data_ok.
// The slave model has per-channel wait counts and programmable responses to exercise skew and backpressure.
module tb_sram_axi_master;

    logic        clk;
    logic        reset;
    logic        req, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok, err;
    logic [31:0] rdata;
    logic [31:0] araddr, awaddr, wdata_o, rdata_i;
    logic        arvalid, arready, rready, rvalid, rlast;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic [3:0]  wstrb_o;

    sram_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req(req), .wr(wr), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rdata_i(rdata_i), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_dok    = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
        bit          is_rd;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- AXI slave model (acts on falling edges) ----------------
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    bit          stray = 0;
    logic [31:0] mem [0:255];

    int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
    bit          ar_fire, r_fire, aw_fire, w_fire, b_fire;
    bit          r_pend, b_pend, aw_got, w_got, stray_live;
    logic [31:0] ar_a, aw_a, w_d;
    logic [3:0]  w_s;

    always @(negedge clk) begin
        if (reset) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; stray_live = 0;
            ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
            ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        end else begin
            if (stray_live) begin rvalid = 0; bvalid = 0; stray_live = 0; end
            // consequences of handshakes on the rising edge just passed
            if (ar_fire) begin r_pend = 1; r_wait = 0; end
            if (r_fire)  begin r_pend = 0; rvalid = 0; end
            if (aw_fire) aw_got = 1;
            if (w_fire)  w_got = 1;
            if (b_fire)  begin b_pend = 0; bvalid = 0; end
            if (aw_got && w_got) begin
                for (int i = 0; i < 4; i++)
                    if (w_s[i]) mem[aw_a[9:2]][8*i +: 8] = w_d[8*i +: 8];
                aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
            end
            // ready decisions for the next rising edge
            arready = 0;
            if (arvalid) begin
                if (ar_wait >= ar_dly) begin arready = 1; ar_wait = 0; end else ar_wait++;
            end
            awready = 0;
            if (awvalid) begin
                if (aw_wait >= aw_dly) begin awready = 1; aw_wait = 0; end else aw_wait++;
            end
            wready = 0;
            if (wvalid) begin
                if (w_wait >= w_dly) begin wready = 1; w_wait = 0; end else w_wait++;
            end
            if (r_pend && !rvalid) begin
                if (r_wait >= r_dly) begin
                    rvalid = 1; rdata_i = mem[ar_a[9:2]]; rresp = rresp_cfg;
                end else r_wait++;
            end
            if (b_pend && !bvalid) begin
                if (b_wait >= b_dly) begin bvalid = 1; bresp = bresp_cfg; end else b_wait++;
            end
            if (stray) begin
                stray = 0; stray_live = 1; rvalid = 1; bvalid = 1; rresp = 2'b00; bresp = 2'b00;
            end
            ar_fire = arvalid && arready; if (ar_fire) ar_a = araddr;
            aw_fire = awvalid && awready; if (aw_fire) aw_a = awaddr;
            w_fire  = wvalid && wready;   if (w_fire) begin w_d = wdata_o; w_s = wstrb_o; end
            r_fire  = rvalid && rready;
            b_fire  = bvalid && bready;
        end
    end

    // ---------------- Scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (data_ok) begin
                n_dok++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_data_ok: got data_ok=1 expected no pending transaction (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_rd) check("rdata", 64'(rdata), 64'(e.rd));
                    check("err", 64'(err), 64'(e.err));
                    check("data_ok_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    // ---------------- Stimulus helpers (called #1 after a rising edge) ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] exp_rd, input logic exp_err, input int extra,
                         input bit hold, output int n);
        bit got;
        req = 1; wr = w; addr = a; wdata = d; wstrb = s;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (addr_ok) got = 1;
        end
        n = cyc;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no addr_ok expected acceptance of addr %0h", a);
        end else begin
            exp_q.push_back('{exp_rd, exp_err, n + 3 + extra, !w});
        end
        sync();
        if (!hold) req = 0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && addr_ok) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
        sync();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    // ---------------- Directed sequence ----------------
    initial begin
        int n, n0, n1, n2, d0;
        reset = 1; req = 0; wr = 0; addr = 0; wdata = 0; wstrb = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata_i = 0; rresp = 0; bresp = 0; rlast = 1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok, err, wlast}), 64'(0));
        check("reset_rdata", 64'(rdata), 64'(0));
        check("reset_addr", 64'({araddr, awaddr}), 64'(0));
        check("reset_wdata", 64'({wdata_o, wstrb_o}), 64'(0));
        check("ar_consts", 64'({arlen, arsize, arburst}), 64'({8'd0, 3'b010, 2'b01}));
        check("aw_consts", 64'({awlen, awsize, awburst}), 64'({8'd0, 3'b010, 2'b01}));
        sync();
        reset = 0;
        @(negedge clk);
        check("idle_addr_ok", 64'(addr_ok), 64'(1));
        sync();

        // write then read, zero-wait slave
        issue(1, 32'h4, 32'habcdaaaa, 4'hF, 32'h0, 0, 0, 0, n);
        wait_idle();
        issue(0, 32'h4, 32'h0, 4'h0, 32'habcdaaaa, 0, 0, 0, n);
        wait_idle();
        // partial-strobe write: only the two low bytes land in a zeroed word
        issue(1, 32'h8, 32'h11223344, 4'h3, 32'h0, 0, 0, 0, n);
        wait_idle();

        // back-to-back reads with req held high
        d0 = n_dok;
        issue(0, 32'h0, 32'h0, 4'h0, 32'h00000000, 0, 0, 1, n0);
        issue(0, 32'h4, 32'h0, 4'h0, 32'habcdaaaa, 0, 0, 1, n1);
        issue(0, 32'h8, 32'h0, 4'h0, 32'h00003344, 0, 0, 0, n2);
        wait_idle();
        check("b2b_accept_1", 64'(n1 - n0), 64'(3));
        check("b2b_accept_2", 64'(n2 - n1), 64'(3));
        check("b2b_pulses", 64'(n_dok - d0), 64'(3));

        // skewed write: AW waits 3 cycles, W immediate
        aw_dly = 3;
        issue(1, 32'hC, 32'h5a5a5a5a, 4'hF, 32'h0, 0, 3, 0, n);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("skew_wvalid", 64'(wvalid), 64'(k == 1));
            check("skew_awvalid", 64'(awvalid), 64'(k <= 4));
            check("skew_bready", 64'(bready), 64'(k == 5));
        end
        aw_dly = 0;
        wait_idle();

        // read backpressure: arready low for 5 cycles
        ar_dly = 5;
        issue(0, 32'hC, 32'h0, 4'h0, 32'h5a5a5a5a, 0, 5, 0, n);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("bp_arvalid", 64'(arvalid), 64'(1));
            check("bp_araddr", 64'(araddr), 64'(32'hC));
            check("bp_addr_ok", 64'(addr_ok), 64'(0));
        end
        @(negedge clk);
        check("bp_rready", 64'({arvalid, rready}), 64'(2'b01));
        ar_dly = 0;
        wait_idle();

        // error responses, then OKAY clears err
        rresp_cfg = 2'b10;
        issue(0, 32'h10, 32'h0, 4'h0, 32'h0, 1, 0, 0, n);
        wait_idle();
        rresp_cfg = 2'b00;
        issue(0, 32'h10, 32'h0, 4'h0, 32'h0, 0, 0, 0, n);
        wait_idle();
        bresp_cfg = 2'b11;
        issue(1, 32'h14, 32'h01020304, 4'hF, 32'h0, 1, 0, 0, n);
        wait_idle();
        bresp_cfg = 2'b00;

        // stray rvalid/bvalid while idle must not complete anything
        d0 = n_dok;
        stray = 1;
        repeat (3) @(negedge clk);
        check("stray_no_data_ok", 64'(n_dok - d0), 64'(0));
        sync();

        // reset while waiting in WR_B; the slave already committed the data
        b_dly = 10;
        issue(1, 32'h4, 32'hdeadbeef, 4'hF, 32'h0, 0, 0, 0, n);
        @(negedge clk);
        sync();
        @(negedge clk);
        check("wrb_bready", 64'(bready), 64'(1));
        sync();
        reset = 1;
        exp_q.delete();
        sync();
        @(negedge clk);
        check("rst_mid_ctrl", 64'({arvalid, rready, awvalid, wvalid, bready, data_ok, addr_ok}), 64'(0));
        sync();
        reset = 0;
        b_dly = 0;
        @(negedge clk);
        check("rst_mid_idle", 64'(addr_ok), 64'(1));
        sync();
        d0 = n_dok;
        issue(0, 32'h4, 32'h0, 4'h0, 32'hdeadbeef, 0, 0, 0, n);
        wait_idle();
        check("post_reset_pulses", 64'(n_dok - d0), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
